rr_arb8: RTL and testbench

- Round-robin arbiter that shares one resource between 8 requesters.
- Produces a one-hot grant, a 3-bit grant index and a valid flag.
- The 3-bit index drives the resource's select/steering logic downstream.
- Grant is held until the owner drops its request, so a multi-cycle transaction is never preempted.
- Fairness comes from a rotating priority pointer.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_arb8_if.sv | 22 ++
 rtl/rr_arb8_pick.sv | 28 ++
 rtl/rr_arb8.sv | 132 +++++++++++++
 tb/tb_rr_arb8.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the rr_arb8 round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters (master) and rr_arb8 (slave).
interface rr_arb8_if;
    import arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_vld, timeout
    );

endinterface

// File: rtl/rr_arb8_pick.sv
// rr_pick: first set request searching circularly upward from ptr.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   rot_oh;
    logic [2*N_REQ-1:0] oh_dbl;

    always_comb begin
        // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
        req_dbl  = {req, req} >> ptr;
        rot      = req_dbl[N_REQ-1:0];
        rot_oh   = rot & (~rot + N_REQ'(1));
        oh_dbl   = {rot_oh, rot_oh} << ptr;
        pick_oh  = oh_dbl[2*N_REQ-1:N_REQ];
        pick_idx = onehot_to_idx(pick_oh);
        pick_vld = |req;
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with grant hold until release.
// Optional hold limit with timeout pulse: define ARB_HOLD_LIMIT_EN.
module rr_arb8
    import arb_pkg::*;
#(
    parameter logic [IDX_W-1:0] PTR_INIT = 3'd0,
    parameter int               HOLD_MAX = 16
) (
    input logic        clk,
    input logic        rst,
    rr_arb8_if.slave   bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arb8: HOLD_MAX must be within 2..255");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             grant_new;
    logic             revoke;

    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    // While busy, the search starts just past the owner so a handoff sees the post-release ptr.
    assign pick_ptr = (state_q == BUSY) ? gnt_idx_q + 3'd1 : ptr_q;

    rr_pick u_pick (
        .req      (bus.req),
        .ptr      (pick_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign revoke = (state_q == BUSY) && (cnt_q == HOLD_LAST);

    always_comb begin
        cnt_d     = '0;
        timeout_d = revoke && bus.req[gnt_idx_q];
        if (state_d == BUSY && !grant_new) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign revoke      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        grant_new = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                gnt_vld_d = 1'b0;
                if (bus.en && pick_vld) begin
                    state_d   = BUSY;
                    gnt_d     = pick_oh;
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    grant_new = 1'b1;
                end
            end
            BUSY: begin
                if (!bus.req[gnt_idx_q] || revoke) begin
                    ptr_d = pick_ptr;
                    if (bus.en && pick_vld) begin
                        gnt_d     = pick_oh;
                        gnt_idx_d = pick_idx;
                        gnt_vld_d = 1'b1;
                        grant_new = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        gnt_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_INIT;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed scenarios plus random traffic against a circular-search model.
module tb_rr_arb8;

    localparam logic [2:0] PTR_INIT_TB = 3'd0;
    localparam int         HOLD_MAX_TB = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    // Model: owner (-1 when idle), rotating pointer, cycles held, timeout flag.
    int   m_owner;
    int   m_ptr;
    int   m_hold;
    logic m_tmo;

    rr_arb8_if bus ();

    rr_arb8 #(
        .PTR_INIT (PTR_INIT_TB),
        .HOLD_MAX (HOLD_MAX_TB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic e, input logic [7:0] q);
        int  k;
        logic lim;
        m_tmo = 1'b0;
        if (r) begin
            m_owner = -1;
            m_ptr   = int'(PTR_INIT_TB);
            m_hold  = 0;
        end else if (m_owner < 0) begin
            k = pick(m_ptr, q);
            if (e && k >= 0) begin
                m_owner = k;
                m_hold  = 0;
            end
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            lim = (m_hold == HOLD_MAX_TB - 1);
`else
            lim = 1'b0;
`endif
            if (!q[m_owner] || lim) begin
                m_tmo = q[m_owner];
                m_ptr = (m_owner + 1) % 8;
                k     = pick(m_ptr, q);
                if (e && k >= 0) begin
                    m_owner = k;
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] e_gnt;
        rst     = r;
        bus.en  = e;
        bus.req = q;
        model_update(r, e, q);
        @(posedge clk);
        #1;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("gnt",     bus.gnt, e_gnt);
        check("gnt_idx", 8'(bus.gnt_idx), (m_owner >= 0) ? 8'(m_owner) : 8'h00);
        check("gnt_vld", 8'(bus.gnt_vld), 8'(m_owner >= 0));
        check("timeout", 8'(bus.timeout), 8'(m_tmo));
    endtask

    initial begin
        logic [7:0] q;
        logic [7:0] e_tmo_gnt;
        logic       e_tmo;
        n_chk   = 0;
        n_fail  = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_tmo   = 1'b0;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.req = 8'h00;

        // Reset with all requesting, then first grant goes to requester 0.
        step(1'b1, 1'b1, 8'hFF);
        check("reset_gnt", bus.gnt, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        check("first_gnt", bus.gnt, 8'h01);

        // Rotation through all eight with a one-cycle drop of the owner's bit.
        for (int o = 0; o < 8; o++) begin
            step(1'b0, 1'b1, 8'hFF);
            step(1'b0, 1'b1, 8'hFF);
            step(1'b0, 1'b1, 8'hFF & ~(8'h01 << ((m_owner < 0) ? 0 : m_owner)));
        end

        // Hold with other requests arriving, then release wraps search to 0.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h08);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h0F);
        step(1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b1, 8'h00);

        // Enable gating and en=0 mid-grant.
        step(1'b0, 1'b0, 8'h20);
        check("en0_gnt", bus.gnt, 8'h00);
        step(1'b0, 1'b1, 8'h20);
        check("en1_gnt", bus.gnt, 8'h20);
        step(1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 8'h20);
        step(1'b0, 1'b0, 8'h00);
        check("en_release", bus.gnt, 8'h00);

        // Reset while requester 6 owns the grant.
        step(1'b0, 1'b1, 8'h40);
        step(1'b0, 1'b1, 8'h40);
        step(1'b1, 1'b1, 8'h40);
        check("rst_mid_gnt", bus.gnt, 8'h00);
        check("rst_mid_tmo", 8'(bus.timeout), 8'h00);

        // Two steady requesters: hold limit alternates them, otherwise 0 keeps it.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h03);
`ifdef ARB_HOLD_LIMIT_EN
            e_tmo_gnt = ((i / 4) % 2 == 0) ? 8'h01 : 8'h02;
            e_tmo     = (i == 4 || i == 8);
`else
            e_tmo_gnt = 8'h01;
            e_tmo     = 1'b0;
`endif
            check("hold_gnt", bus.gnt, e_tmo_gnt);
            check("hold_tmo", 8'(bus.timeout), 8'(e_tmo));
        end

        // Random traffic; owner tends to keep its request to exercise long holds.
        for (int n = 0; n < 400; n++) begin
            q = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) q = q & 8'($urandom_range(0, 255));
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) q[m_owner] = 1'b1;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
